// File: rtl/vmx_array_ctrl.sv
// vmx_array_ctrl: command sequencer for the SIZE x SIZE weight-stationary vmx
// PE array. Loads weights row by row, streams compute vectors into the array's
// top edge with per-column skew, and de-skews the row products into one
// aligned result word per accepted vector.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready/op/len/simd   command interface (accepted only in IDLE)
//   in_valid/ready/data      input vector / weight word stream
//   out_valid/out_data       aligned row products (no backpressure)
//   busy, done               status; done pulses one cycle per command
//   arr_is_weight/simd_mode/vector   skewed drive into the array top edge
//   arr_product              per-row products from the array
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_LOAD    | accepting SIZE weight words, word k tagged for row k
// S_COMPUTE | accepting cmd_len vectors
// S_DRAIN   | LAT cycles for the last word to reach out_data
// S_DONE    | one-cycle done pulse
module vmx_array_ctrl #(
   parameter int SIZE           = 4,
   parameter int VECTOR_BITLEN  = 16,
   parameter int PRODUCT_BITLEN = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_op,
   input  logic [15:0]                      cmd_len,
   input  logic [SIZE-1:0]                  cmd_simd,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [VECTOR_BITLEN*SIZE-1:0]    in_data,
   output logic                             out_valid,
   output logic [PRODUCT_BITLEN*SIZE-1:0]   out_data,
   output logic                             busy,
   output logic                             done,
   output logic [8*SIZE-1:0]                arr_is_weight,
   output logic [SIZE-1:0]                  arr_simd_mode,
   output logic [VECTOR_BITLEN*SIZE-1:0]    arr_vector,
   input  logic [PRODUCT_BITLEN*SIZE-1:0]   arr_product
);

   localparam int LAT = 2*SIZE + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]                        state;
   logic [15:0]                       rem;
   logic [7:0]                        drain_cnt;
   logic [SIZE-1:0]                   simd_lat;
   logic                              accept;
   logic [7:0]                        tag_next;
   logic [2*SIZE-1:0]                 cv_pipe;
   logic [PRODUCT_BITLEN*SIZE-1:0]    aligned_all;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   // rem never reaches zero inside LOAD/COMPUTE, so the state alone decides
   assign in_ready  = (state == S_LOAD) || (state == S_COMPUTE);
   assign accept    = in_valid & in_ready;
   // rem counts down from SIZE in LOAD, so the k-th word gets tag k+1
   assign tag_next  = 8'(SIZE + 1) - rem[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rem       <= '0;
         drain_cnt <= '0;
         simd_lat  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  simd_lat <= cmd_simd;
                  if (!cmd_op) begin
                     state <= S_LOAD;
                     rem   <= 16'(SIZE);
                  end else if (cmd_len == 16'd0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_COMPUTE;
                     rem   <= cmd_len;
                  end
               end
            end
            S_LOAD, S_COMPUTE: begin
               if (accept) begin
                  rem <= rem - 16'd1;
                  if (rem == 16'd1) begin
                     state     <= S_DRAIN;
                     drain_cnt <= 8'(LAT);
                  end
               end
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt - 8'd1;
               if (drain_cnt == 8'd1) state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // marks compute words; bit k is the word accepted k+1 cycles ago
   always_ff @(posedge clk) begin
      if (rst) cv_pipe <= '0;
      else     cv_pipe <= {cv_pipe[2*SIZE-2:0], accept && (state == S_COMPUTE)};
   end

   // input skew: column j sits behind j+1 registers (input register + j delays)
   for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic [VECTOR_BITLEN-1:0] d_pipe [0:j];
      logic [7:0]               t_pipe [0:j];
      logic                     s_pipe [0:j];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k <= j; k++) begin
               d_pipe[k] <= '0;
               t_pipe[k] <= '0;
               s_pipe[k] <= 1'b0;
            end
         end else begin
            d_pipe[0] <= accept ? in_data[j*VECTOR_BITLEN +: VECTOR_BITLEN] : '0;
            t_pipe[0] <= (accept && (state == S_LOAD)) ? tag_next : 8'd0;
            s_pipe[0] <= simd_lat[j];
            for (int k = 1; k <= j; k++) begin
               d_pipe[k] <= d_pipe[k-1];
               t_pipe[k] <= t_pipe[k-1];
               s_pipe[k] <= s_pipe[k-1];
            end
         end
      end

      assign arr_vector[j*VECTOR_BITLEN +: VECTOR_BITLEN] = d_pipe[j];
      assign arr_is_weight[j*8 +: 8]                      = t_pipe[j];
      assign arr_simd_mode[j]                             = s_pipe[j];
   end

   // de-skew: row i leaves the array i cycles after row 0, so it is held
   // SIZE-1-i cycles to line up with the last row
   for (genvar i = 0; i < SIZE; i++) begin : g_row
      localparam int D = SIZE - 1 - i;
      if (D == 0) begin : g_nodly
         assign aligned_all[i*PRODUCT_BITLEN +: PRODUCT_BITLEN] =
            arr_product[i*PRODUCT_BITLEN +: PRODUCT_BITLEN];
      end else begin : g_dly
         logic [PRODUCT_BITLEN-1:0] dly [0:D-1];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < D; k++) dly[k] <= '0;
            end else begin
               dly[0] <= arr_product[i*PRODUCT_BITLEN +: PRODUCT_BITLEN];
               for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
            end
         end
         assign aligned_all[i*PRODUCT_BITLEN +: PRODUCT_BITLEN] = dly[D-1];
      end
   end

   // out_data holds between results
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= cv_pipe[2*SIZE-1];
         if (cv_pipe[2*SIZE-1]) out_data <= aligned_all;
      end
   end

endmodule
